// File: rtl/multi_panel_display_controller.sv
// 640x480@60 VGA controller that splits the screen into N_PANELS horizontal bands.
// Each band shows a status block and a temperature bar, using inputs latched once per frame.
module multi_panel_display_controller #(
  parameter int unsigned N_PANELS     = 4,
  parameter int unsigned TEMP_W       = 10,
  parameter int unsigned DIV_THICK    = 10,
  parameter int unsigned STATUS_W_PX  = 64,
  parameter int unsigned BAR_X0       = 80,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET,
  input  logic [2*N_PANELS-1:0]        PANEL_STATUS,
  input  logic [TEMP_W*N_PANELS-1:0]   PANEL_TEMP,
  output logic                         VGA_CLK,
  output logic                         VGA_HS,
  output logic                         VGA_VS,
  output logic                         VGA_BLANK_N,
  output logic [7:0]                   VGA_R,
  output logic [7:0]                   VGA_G,
  output logic [7:0]                   VGA_B,
  output logic                         FRAME_TICK
);

  localparam int unsigned PanelH = 480 / N_PANELS;
  localparam int unsigned BarMax = 640 - BAR_X0;
  localparam int unsigned FcW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0] HActive   = 10'd640;
  localparam logic [9:0] HSyncLo   = 10'd656;
  localparam logic [9:0] HSyncHi   = 10'd751;
  localparam logic [9:0] HMax      = 10'd799;
  localparam logic [9:0] VActive   = 10'd480;
  localparam logic [9:0] VSyncLo   = 10'd490;
  localparam logic [9:0] VSyncHi   = 10'd491;
  localparam logic [9:0] VMax      = 10'd524;
  localparam logic [9:0] StatusW   = 10'(STATUS_W_PX);
  localparam logic [8:0] RowMax    = 9'(PanelH - 1);
  localparam logic [8:0] DivRow    = 9'(PanelH - DIV_THICK);
  localparam logic [8:0] BarLo     = 9'(PanelH / 4);
  localparam logic [8:0] BarHi     = 9'((3 * PanelH) / 4);
  localparam logic [3:0] PnlN      = 4'(N_PANELS);
  localparam logic [3:0] PnlLast   = 4'(N_PANELS - 1);
  localparam logic [FcW-1:0] FcMax = FcW'(BLINK_FRAMES - 1);

  logic                        pix_en_q, pix_en_d;
  logic [9:0]                  hc_q, hc_d;
  logic [9:0]                  vc_q, vc_d;
  logic [8:0]                  row_q, row_d;
  logic [3:0]                  pnl_q, pnl_d;
  logic [FcW-1:0]              frame_cnt_q, frame_cnt_d;
  logic                        blink_q, blink_d;
  logic                        tick_q, tick_d;
  logic [2*N_PANELS-1:0]       st_sh_q, st_sh_d;
  logic [TEMP_W*N_PANELS-1:0]  tp_sh_q, tp_sh_d;
  logic                        hs_q, hs_d;
  logic                        vs_q, vs_d;
  logic                        blank_n_q, blank_n_d;
  logic [2:0]                  rgb_q, rgb_d;

  logic [1:0]        cur_st;
  logic [TEMP_W-1:0] cur_tp;
  logic [31:0]       bar_len;
  logic [2:0]        pix_rgb;
  logic              snap;

  // Select the shadowed fields of the panel currently being scanned.
  always_comb begin
    cur_st = 2'b00;
    cur_tp = '0;
    for (int i = 0; i < N_PANELS; i++) begin
      if (pnl_q == 4'(i)) begin
        cur_st = st_sh_q[2*i +: 2];
        cur_tp = tp_sh_q[TEMP_W*i +: TEMP_W];
      end
    end
    bar_len = (32'(cur_tp) > BarMax) ? BarMax : 32'(cur_tp);
  end

  always_comb begin
    pix_rgb = 3'b111;
    if (hc_q >= HActive || vc_q >= VActive) begin
      pix_rgb = 3'b000;
    end else if (pnl_q >= PnlN) begin
      pix_rgb = 3'b111;
    end else if (row_q >= DivRow && pnl_q < PnlLast) begin
      pix_rgb = 3'b000;
    end else if (hc_q < StatusW) begin
      unique case (cur_st)
        2'b00:   pix_rgb = 3'b010;
        2'b01:   pix_rgb = 3'b110;
        2'b10:   pix_rgb = blink_q ? 3'b100 : 3'b111;
        default: pix_rgb = 3'b000;
      endcase
    end else if (32'(hc_q) >= BAR_X0 && 32'(hc_q) < BAR_X0 + bar_len &&
                 row_q >= BarLo && row_q < BarHi) begin
      pix_rgb = 3'b001;
    end else begin
      pix_rgb = 3'b111;
    end
  end

  assign snap = pix_en_q && (hc_q == 10'd0) && (vc_q == VActive);

  always_comb begin
    pix_en_d    = ~pix_en_q;
    hc_d        = hc_q;
    vc_d        = vc_q;
    row_d       = row_q;
    pnl_d       = pnl_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    tick_d      = 1'b0;
    st_sh_d     = st_sh_q;
    tp_sh_d     = tp_sh_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    blank_n_d   = blank_n_q;
    rgb_d       = rgb_q;
    if (pix_en_q) begin
      // All video outputs come from the same (hc, vc) so they stay aligned.
      hs_d      = ~(hc_q >= HSyncLo && hc_q <= HSyncHi);
      vs_d      = ~(vc_q >= VSyncLo && vc_q <= VSyncHi);
      blank_n_d = (hc_q < HActive) && (vc_q < VActive);
      rgb_d     = pix_rgb;
      if (hc_q == HMax) begin
        hc_d = 10'd0;
        if (vc_q == VMax) begin
          vc_d  = 10'd0;
          row_d = 9'd0;
          pnl_d = 4'd0;
        end else begin
          vc_d = vc_q + 10'd1;
          if (row_q == RowMax) begin
            row_d = 9'd0;
            pnl_d = pnl_q + 4'd1;
          end else begin
            row_d = row_q + 9'd1;
          end
        end
      end else begin
        hc_d = hc_q + 10'd1;
      end
      if (snap) begin
        st_sh_d = PANEL_STATUS;
        tp_sh_d = PANEL_TEMP;
        tick_d  = 1'b1;
        if (frame_cnt_q == FcMax) begin
          frame_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      pix_en_q    <= 1'b0;
      hc_q        <= 10'd0;
      vc_q        <= 10'd0;
      row_q       <= 9'd0;
      pnl_q       <= 4'd0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      tick_q      <= 1'b0;
      st_sh_q     <= '0;
      tp_sh_q     <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_n_q   <= 1'b0;
      rgb_q       <= 3'b000;
    end else begin
      pix_en_q    <= pix_en_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      row_q       <= row_d;
      pnl_q       <= pnl_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      tick_q      <= tick_d;
      st_sh_q     <= st_sh_d;
      tp_sh_q     <= tp_sh_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_n_q   <= blank_n_d;
      rgb_q       <= rgb_d;
    end
  end

  assign VGA_CLK     = pix_en_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = {8{rgb_q[2]}};
  assign VGA_G       = {8{rgb_q[1]}};
  assign VGA_B       = {8{rgb_q[0]}};
  assign FRAME_TICK  = tick_q;

endmodule

// File: tb/tb_multi_panel_display_controller.sv
// Bench for multi_panel_display_controller: a 4-panel (blink 2) and a 7-panel instance,
// every pixel checked against an arithmetic screen model, plus a table of spot pixels.
module tb_multi_panel_display_controller;

  localparam int FramePix = 420000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic [7:0]  st_a;
  logic [39:0] tp_a;
  logic [13:0] st_b;
  logic [69:0] tp_b;
  logic        clk_a, hs_a, vs_a, bl_a, tick_a;
  logic        clk_b, hs_b, vs_b, bl_b, tick_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  multi_panel_display_controller #(.N_PANELS(4), .BLINK_FRAMES(2)) dut_a (
    .CLOCK_50(clk), .RESET(rst), .PANEL_STATUS(st_a), .PANEL_TEMP(tp_a),
    .VGA_CLK(clk_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .FRAME_TICK(tick_a)
  );

  multi_panel_display_controller #(.N_PANELS(7)) dut_b (
    .CLOCK_50(clk), .RESET(rst), .PANEL_STATUS(st_b), .PANEL_TEMP(tp_b),
    .VGA_CLK(clk_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .FRAME_TICK(tick_b)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  // Screen colour of pixel (x,y) straight from the geometry rules.
  function automatic logic [2:0] ref_rgb(input int x, input int y, input int np,
                                         input logic [15:0] st, input logic [79:0] tp,
                                         input bit ph);
    int h, p, r, len;
    logic [1:0] s;
    if (x >= 640 || y >= 480) return 3'b000;
    h = 480 / np;
    p = y / h;
    r = y % h;
    if (p >= np) return 3'b111;
    if (r >= h - 10 && p < np - 1) return 3'b000;
    s = st[2*p +: 2];
    if (x < 64) begin
      case (s)
        2'b00:   return 3'b010;
        2'b01:   return 3'b110;
        2'b10:   return ph ? 3'b100 : 3'b111;
        default: return 3'b000;
      endcase
    end
    len = int'(tp[10*p +: 10]);
    if (len > 560) len = 560;
    if (x >= 80 && x < 80 + len && r >= h / 4 && r < (3 * h) / 4) return 3'b001;
    return 3'b111;
  endfunction

  function automatic logic [26:0] ref_out(input int x, input int y, input int np,
                                          input logic [15:0] st, input logic [79:0] tp,
                                          input bit ph);
    logic [2:0] c;
    c = ref_rgb(x, y, np, st, tp, ph);
    return {!(x >= 656 && x <= 751), !(y >= 490 && y <= 491), (x < 640 && y < 480),
            {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  int          edges, snaps, cur_n = -1;
  int          n, x, y, f;
  bit          pix, tick_e;
  logic [26:0] ea, eb;
  logic [15:0] sh_st_a, sh_st_b;
  logic [79:0] sh_tp_a, sh_tp_b;
  int          bad_a, bad_b, aux_bad;
  int          hs_low, vs_low, blank_cnt, hs_fall_n, vs_fall_n;
  logic        hs_prev, vs_prev;
  bit          capture_en = 1'b0;
  bit          rand_en = 1'b0;
  logic [2:0]  fb  [0:5*307200-1];
  logic [2:0]  fbb [0:307199];

  // Pixel edges are the even CLOCK_50 edges after reset release; pixel n is shown after edge 2n+2.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      edges = 0; snaps = 0; cur_n = -1;
      sh_st_a = '0; sh_st_b = '0; sh_tp_a = '0; sh_tp_b = '0;
      bad_a = 0; bad_b = 0; aux_bad = 0;
      hs_low = 0; vs_low = 0; blank_cnt = 0; hs_fall_n = -1; vs_fall_n = -1;
      hs_prev = 1'b1; vs_prev = 1'b1;
    end else begin
      edges++;
      pix = (edges % 2 == 0);
      if (clk_a != !pix || clk_b != !pix) aux_bad++;
      tick_e = 1'b0;
      if (pix) begin
        n = edges / 2 - 1;
        x = n % 800;
        y = (n / 800) % 525;
        f = n / FramePix;
        tick_e = (x == 0 && y == 480);
        ea = ref_out(x, y, 4, sh_st_a, sh_tp_a, ((snaps / 2) % 2) == 1);
        eb = ref_out(x, y, 7, sh_st_b, sh_tp_b, ((snaps / 30) % 2) == 1);
        if ({hs_a, vs_a, bl_a, r_a, g_a, b_a} != ea) bad_a++;
        if ({hs_b, vs_b, bl_b, r_b, g_b, b_b} != eb) bad_b++;
        if (!hs_a) hs_low++;
        if (!vs_a) vs_low++;
        if (bl_a) blank_cnt++;
        if (hs_prev && !hs_a) begin
          if (hs_fall_n >= 0 && n < 3200) chk("HS period (pixels)", n - hs_fall_n, 800);
          hs_fall_n = n;
        end
        if (vs_prev && !vs_a) begin
          if (vs_fall_n >= 0 && f < 2) chk("VS period (pixels)", n - vs_fall_n, FramePix);
          vs_fall_n = n;
        end
        hs_prev = hs_a;
        vs_prev = vs_a;
        if (capture_en && x < 640 && y < 480) begin
          if (f < 5) fb[f*307200 + y*640 + x] = {r_a[0], g_a[0], b_a[0]};
          if (f == 1) fbb[y*640 + x] = {r_b[0], g_b[0], b_b[0]};
        end
        if (x == 799) begin
          chk($sformatf("A pixel mismatches f%0d y%0d", f, y), bad_a, 0);
          chk($sformatf("B pixel mismatches f%0d y%0d", f, y), bad_b, 0);
          chk($sformatf("VGA_CLK/FRAME_TICK errors f%0d y%0d", f, y), aux_bad, 0);
          if (n < 2400) chk("HS low width", hs_low, 96);
          bad_a = 0; bad_b = 0; aux_bad = 0; hs_low = 0;
          if (y == 524) begin
            if (f < 2) begin
              chk("VS low pixels per frame", vs_low, 1600);
              chk("BLANK_N high pixels per frame", blank_cnt, 307200);
            end
            vs_low = 0;
            blank_cnt = 0;
          end
        end
        if (tick_e) begin
          snaps++;
          sh_st_a = 16'(st_a);
          sh_st_b = 16'(st_b);
          sh_tp_a = 80'(tp_a);
          sh_tp_b = 80'(tp_b);
        end
        cur_n = n;
      end
      if (tick_a != tick_e || tick_b != tick_e) aux_bad++;
    end
  end

  always @(negedge clk) begin
    if (rand_en && !rst && $urandom_range(0, 499) == 0) begin
      st_b       = 14'($urandom);
      tp_b       = 70'({$urandom, $urandom, $urandom});
      st_a[7:2]  = 6'($urandom);
      tp_a[39:10] = 30'($urandom);
    end
  end

  task automatic wait_pix(input int target);
    while (cur_n < target) @(negedge clk);
  endtask

  typedef struct packed {
    logic [2:0] f;
    logic [9:0] x;
    logic [9:0] y;
    logic       use_b;
    logic [2:0] exp;
  } vec_t;

  vec_t vq[$];
  int   idx;
  logic [2:0] act;

  initial begin
    // DUT A frame 1 spot pixels
    vq.push_back('{3'd1, 10'd10,  10'd50,  1'b0, 3'b010});
    vq.push_back('{3'd1, 10'd10,  10'd170, 1'b0, 3'b110});
    vq.push_back('{3'd1, 10'd10,  10'd290, 1'b0, 3'b000});
    vq.push_back('{3'd1, 10'd300, 10'd115, 1'b0, 3'b000});
    vq.push_back('{3'd1, 10'd300, 10'd475, 1'b0, 3'b111});
    vq.push_back('{3'd1, 10'd80,  10'd30,  1'b0, 3'b001});
    vq.push_back('{3'd1, 10'd179, 10'd89,  1'b0, 3'b001});
    vq.push_back('{3'd1, 10'd180, 10'd30,  1'b0, 3'b111});
    vq.push_back('{3'd1, 10'd79,  10'd50,  1'b0, 3'b111});
    vq.push_back('{3'd1, 10'd100, 10'd29,  1'b0, 3'b111});
    vq.push_back('{3'd1, 10'd100, 10'd90,  1'b0, 3'b111});
    vq.push_back('{3'd1, 10'd200, 10'd150, 1'b0, 3'b111});
    vq.push_back('{3'd1, 10'd639, 10'd270, 1'b0, 3'b001});
    vq.push_back('{3'd1, 10'd639, 10'd400, 1'b0, 3'b001});
    vq.push_back('{3'd1, 10'd179, 10'd50,  1'b0, 3'b001});
    vq.push_back('{3'd1, 10'd180, 10'd50,  1'b0, 3'b111});
    vq.push_back('{3'd2, 10'd379, 10'd50,  1'b0, 3'b001});
    vq.push_back('{3'd2, 10'd380, 10'd50,  1'b0, 3'b111});
    vq.push_back('{3'd0, 10'd100, 10'd50,  1'b0, 3'b111});
    // status block of panel 0 frame by frame
    vq.push_back('{3'd0, 10'd10,  10'd10,  1'b0, 3'b010});
    vq.push_back('{3'd1, 10'd10,  10'd10,  1'b0, 3'b010});
    vq.push_back('{3'd2, 10'd10,  10'd10,  1'b0, 3'b100});
    vq.push_back('{3'd3, 10'd10,  10'd10,  1'b0, 3'b100});
    vq.push_back('{3'd4, 10'd10,  10'd10,  1'b0, 3'b111});
    // DUT B (7 panels, height 68) frame 1
    vq.push_back('{3'd1, 10'd300, 10'd477, 1'b1, 3'b111});
    vq.push_back('{3'd1, 10'd10,  10'd476, 1'b1, 3'b111});
    vq.push_back('{3'd1, 10'd10,  10'd475, 1'b1, 3'b110});
    vq.push_back('{3'd1, 10'd10,  10'd408, 1'b1, 3'b110});
    vq.push_back('{3'd1, 10'd10,  10'd407, 1'b1, 3'b000});
    vq.push_back('{3'd1, 10'd10,  10'd397, 1'b1, 3'b010});
    vq.push_back('{3'd1, 10'd279, 10'd425, 1'b1, 3'b001});
    vq.push_back('{3'd1, 10'd280, 10'd425, 1'b1, 3'b111});
    vq.push_back('{3'd1, 10'd100, 10'd424, 1'b1, 3'b111});
    vq.push_back('{3'd1, 10'd100, 10'd458, 1'b1, 3'b001});
    vq.push_back('{3'd1, 10'd100, 10'd459, 1'b1, 3'b111});

    st_a = 8'b00_11_01_00;
    tp_a = {10'd560, 10'd700, 10'd0, 10'd100};
    st_b = 14'h1000;
    tp_b = {10'd200, 60'd0};
    rst = 1'b1;
    capture_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_pix(FramePix + 200*800);
    st_a[1:0] = 2'b10;
    tp_a[9:0] = 10'd300;
    wait_pix(2*FramePix);
    rand_en = 1'b1;
    wait_pix(4*FramePix + 300*800);

    rand_en = 1'b0;
    capture_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("A outputs on reset assertion", {clk_a, hs_a, vs_a, bl_a, r_a, g_a, b_a, tick_a},
        {1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0});
    chk("B outputs on reset assertion", {clk_b, hs_b, vs_b, bl_b, r_b, g_b, b_b, tick_b},
        {1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("BLANK_N after first edge", bl_a, 0);
    chk("VGA_CLK after first edge", clk_a, 1);
    @(posedge clk);
    #2;
    chk("first pixel after reset", {hs_a, vs_a, bl_a, r_a, g_a, b_a},
        {3'b111, 8'h00, 8'hFF, 8'h00});

    foreach (vq[i]) begin
      idx = int'(vq[i].y) * 640 + int'(vq[i].x);
      act = vq[i].use_b ? fbb[idx] : fb[int'(vq[i].f) * 307200 + idx];
      chk($sformatf("vector %0d %s f%0d x%0d y%0d rgb", i, vq[i].use_b ? "B" : "A",
                    vq[i].f, vq[i].x, vq[i].y), act, vq[i].exp);
    end

    wait_pix(3*800);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
